mb_seq: RTL

MB_SEQ -- requirements
Module: mb_seq

---
 rtl/mb_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mb_seq.sv
// MB word-buffer sequencer: memory fill, writeback drain and single-word EBOX/channel loads.
// Define MB_SEQ_RR_EN for round-robin EBOX/channel arbitration; the default is fixed priority.
module mb_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fill_req,
    input  logic       wb_req,
    input  logic       ebox_req,
    input  logic [1:0] ebox_word,
    input  logic       chan_req,
    input  logic [1:0] chan_word,
    input  logic       mem_word_valid,
    input  logic [1:0] mem_word_num,
    input  logic       mem_nxm,
    input  logic       mem_wr_ack,
    output logic       ebox_ack,
    output logic       chan_ack,
    output logic [3:0] mb_load,
    output logic [2:0] mb_in_sel,
    output logic [1:0] mb_sel,
    output logic       mb_sel_hold,
    output logic       mem_wr_valid,
    output logic       fill_done,
    output logic       wb_done,
    output logic       nxm_err,
    output logic       busy,
    output logic [3:0] word_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        LOAD  = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] word_valid_reg, word_valid_next;
    logic [1:0] mb_sel_reg, mb_sel_next;
    logic [1:0] load_word_reg, load_word_next;
    logic       load_chan_reg, load_chan_next;
    logic       fill_done_reg, fill_done_next;
    logic       wb_done_reg, wb_done_next;
    logic       nxm_err_reg, nxm_err_next;
    logic       grant_ebox, grant_chan;
    logic       arb_grant;

    // A single-word load is only granted when nothing with higher priority is asking.
    assign arb_grant = (state_reg == IDLE) && !wb_req && !fill_req && (ebox_req || chan_req);

`ifdef MB_SEQ_RR_EN
    logic last_ebox_reg;

    // On a tie the requester granted last time yields; reset leaves EBOX favoured.
    assign grant_ebox = ebox_req && (!chan_req || !last_ebox_reg);
    assign grant_chan = chan_req && !grant_ebox;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ebox_reg <= 1'b0;
        end else if (arb_grant) begin
            last_ebox_reg <= grant_ebox;
        end
    end
`else
    assign grant_ebox = ebox_req;
    assign grant_chan = chan_req && !ebox_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            word_valid_reg <= 4'b0000;
            mb_sel_reg     <= 2'd0;
            load_word_reg  <= 2'd0;
            load_chan_reg  <= 1'b0;
            fill_done_reg  <= 1'b0;
            wb_done_reg    <= 1'b0;
            nxm_err_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            word_valid_reg <= word_valid_next;
            mb_sel_reg     <= mb_sel_next;
            load_word_reg  <= load_word_next;
            load_chan_reg  <= load_chan_next;
            fill_done_reg  <= fill_done_next;
            wb_done_reg    <= wb_done_next;
            nxm_err_reg    <= nxm_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        word_valid_next = word_valid_reg;
        mb_sel_next     = mb_sel_reg;
        load_word_next  = load_word_reg;
        load_chan_next  = load_chan_reg;
        fill_done_next  = 1'b0;
        wb_done_next    = 1'b0;
        nxm_err_next    = 1'b0;
        mb_load         = 4'b0000;
        mb_in_sel       = 3'b000;
        mb_sel_hold     = 1'b1;
        mem_wr_valid    = 1'b0;
        ebox_ack        = 1'b0;
        chan_ack        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (wb_req) begin
                    state_next  = DRAIN;
                    mb_sel_next = 2'd0;
                end else if (fill_req) begin
                    state_next      = FILL;
                    word_valid_next = 4'b0000;
                end else if (grant_ebox) begin
                    state_next     = LOAD;
                    load_word_next = ebox_word;
                    load_chan_next = 1'b0;
                end else if (grant_chan) begin
                    state_next     = LOAD;
                    load_word_next = chan_word;
                    load_chan_next = 1'b1;
                end
            end
            FILL: begin
                mb_in_sel = 3'b100;
                if (mem_nxm) begin
                    // Abort: the word on the bus is not trusted, so nothing is loaded.
                    state_next      = IDLE;
                    word_valid_next = 4'b0000;
                    nxm_err_next    = 1'b1;
                end else if (mem_word_valid) begin
                    mb_load         = 4'b0001 << mem_word_num;
                    word_valid_next = word_valid_reg | mb_load;
                    if (word_valid_next == 4'b1111) begin
                        state_next     = IDLE;
                        fill_done_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                mem_wr_valid = 1'b1;
                mb_sel_hold  = 1'b0;
                if (mem_wr_ack) begin
                    mb_sel_next = mb_sel_reg + 2'd1;
                    if (mb_sel_reg == 2'd3) begin
                        state_next   = IDLE;
                        wb_done_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_next = IDLE;
                // A requester that dropped its request before the ack has withdrawn it.
                if (load_chan_reg) begin
                    mb_in_sel = 3'b011;
                    if (chan_req) begin
                        mb_load  = 4'b0001 << load_word_reg;
                        chan_ack = 1'b1;
                    end
                end else begin
                    mb_in_sel = 3'b010;
                    if (ebox_req) begin
                        mb_load  = 4'b0001 << load_word_reg;
                        ebox_ack = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mb_sel     = mb_sel_reg;
    assign word_valid = word_valid_reg;
    assign busy       = (state_reg != IDLE);
    assign fill_done  = fill_done_reg;
    assign wb_done    = wb_done_reg;
    assign nxm_err    = nxm_err_reg;

endmodule
